// File: rtl/trigger_crossbar_matrix.sv
// Parametrised trigger crossbar: routes NUM_IN trigger inputs to NUM_OUT outputs with
// per-output mode, per-input saturating edge counters and activity LED stretchers.
module trigger_crossbar_matrix #(
  parameter int NUM_IN     = 12,
  parameter int NUM_OUT    = 12,
  parameter int LED_CYCLES = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  trig_in,
  output logic [NUM_OUT-1:0] trig_out,
  output logic [NUM_IN-1:0]  trig_in_led,
  output logic [NUM_OUT-1:0] trig_out_led,
  input  logic               cfg_wr_en,
  input  logic               cfg_rd_en,
  input  logic [9:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               cfg_rd_valid
);

  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int LED_W = $clog2(LED_CYCLES + 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_PASS    = 2'd1,
    MODE_INV     = 2'd2,
    MODE_STRETCH = 2'd3
  } mode_t;

  logic [NUM_IN-1:0]  sync1, sync2, prev, in_edge, edge_q;
  logic [NUM_OUT-1:0] out_s1, out_s2, out_prev, out_edge;
  logic [31:0]        cfg_word [NUM_OUT];
  logic [31:0]        cnt_word [NUM_IN];
  logic [31:0]        rd_next;
  logic               unused_wdata;

  // Reserved write-data bits are intentionally dropped.
  assign unused_wdata = ^cfg_wdata;

  // Input synchronizer, edge-detect register and a one-cycle delayed edge for stretch mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= trig_in;
      sync2  <= sync1;
      prev   <= sync2;
      edge_q <= in_edge;
    end
  end

  assign in_edge = sync2 & ~prev;

  // Output activity is detected on a synchronized copy since passthrough outputs are async.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_s1   <= '0;
      out_s2   <= '0;
      out_prev <= '0;
    end else begin
      out_s1   <= trig_out;
      out_s2   <= out_s1;
      out_prev <= out_s2;
    end
  end

  assign out_edge = out_s2 & ~out_prev;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic [SEL_W-1:0] sel;
    mode_t            mode;
    logic [15:0]      len;
    logic [15:0]      str_cnt;
    logic [LED_W-1:0] led_cnt;
    logic             wr_hit, sel_ok, src_edge, out_bit;
    logic [31:0]      word;

    assign wr_hit   = cfg_wr_en && (cfg_addr == 10'(k));
    assign sel_ok   = ({1'b0, sel} < (SEL_W + 1)'(NUM_IN));
    assign src_edge = sel_ok ? edge_q[sel] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sel  <= '0;
        mode <= MODE_OFF;
        len  <= '0;
      end else if (wr_hit) begin
        sel  <= cfg_wdata[SEL_W-1:0];
        mode <= mode_t'(cfg_wdata[9:8]);
        len  <= cfg_wdata[31:16];
      end
    end

    // Stretch counter: any config write cancels a pulse, a new edge reloads it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        str_cnt <= '0;
      end else if (wr_hit) begin
        str_cnt <= '0;
      end else if (mode == MODE_STRETCH && src_edge) begin
        str_cnt <= (len == 16'd0) ? 16'd1 : len;
      end else if (str_cnt != 16'd0) begin
        str_cnt <= str_cnt - 16'd1;
      end
    end

    always_comb begin
      out_bit = 1'b0;
      case (mode)
        MODE_PASS:    out_bit = sel_ok & trig_in[sel];
        MODE_INV:     out_bit = sel_ok & ~trig_in[sel];
        MODE_STRETCH: out_bit = sel_ok & (str_cnt != 16'd0);
        default:      out_bit = 1'b0;
      endcase
    end

    assign trig_out[k] = out_bit;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        led_cnt <= '0;
      end else if (out_edge[k]) begin
        led_cnt <= LED_W'(LED_CYCLES);
      end else if (led_cnt != '0) begin
        led_cnt <= led_cnt - 1'b1;
      end
    end

    assign trig_out_led[k] = (led_cnt != '0);

    always_comb begin
      word            = '0;
      word[SEL_W-1:0] = sel;
      word[9:8]       = mode;
      word[31:16]     = len;
    end

    assign cfg_word[k] = word;
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    logic [31:0]      event_cnt;
    logic [LED_W-1:0] led_cnt;
    logic             clr_hit;

    assign clr_hit = cfg_wr_en && (cfg_addr == 10'(32'h200 + i));

    // A clear on the same cycle as an edge wins; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        event_cnt <= '0;
      end else if (clr_hit) begin
        event_cnt <= '0;
      end else if (in_edge[i] && (event_cnt != 32'hFFFF_FFFF)) begin
        event_cnt <= event_cnt + 32'd1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        led_cnt <= '0;
      end else if (in_edge[i]) begin
        led_cnt <= LED_W'(LED_CYCLES);
      end else if (led_cnt != '0) begin
        led_cnt <= led_cnt - 1'b1;
      end
    end

    assign trig_in_led[i] = (led_cnt != '0);
    assign cnt_word[i]    = event_cnt;
  end

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cfg_addr == 10'(k)) rd_next = cfg_word[k];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (cfg_addr == 10'(32'h200 + i)) rd_next = cnt_word[i];
    end
  end

  // Read data is captured from pre-update state, so a same-cycle write or edge is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdata    <= '0;
      cfg_rd_valid <= 1'b0;
    end else begin
      cfg_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) cfg_rdata <= rd_next;
    end
  end

endmodule
